// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA priority resolver.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } resolverState_t;

  localparam int unsigned MAX_CHANNELS = 8;

  // Rotating pointer after channel k completes: k+1 wraps to 0 at n.
  function automatic int unsigned nextPointer(input int unsigned k, input int unsigned n);
    return ((k + 32'd1) >= n) ? 32'd0 : (k + 32'd1);
  endfunction

endpackage

// File: rtl/dma_rotating_arbiter.sv
// Combinational rotating-priority picker: lowest set request at or after ptr_i wins.
module dma_rotating_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned CH_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [CH_W-1:0] winner_o,
  output logic            valid_o
);

  localparam logic [CH_W:0] N_W = (CH_W+1)'(N);

  logic [N-1:0]    rot;
  logic [CH_W-1:0] offset;
  logic [CH_W:0]   sum;

  // Rotate the doubled vector so ptr_i lands at bit 0, encode, then rotate the index back.
  always_comb begin
    rot    = N'({req_i, req_i} >> ptr_i);
    offset = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rot[i]) offset = CH_W'(i);
    end
    sum = {1'b0, ptr_i} + {1'b0, offset};
    if (sum >= N_W) sum = sum - N_W;
    winner_o = sum[CH_W-1:0];
    valid_o  = |req_i;
  end

endmodule

// File: rtl/dma_priority_resolver.sv
// N-channel DMA request resolver: samples requests, arbitrates fixed/rotating,
// raises hrq and drives one-hot dack under timing-and-control strobes.
module dma_priority_resolver
  import dma_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_CHANNELS-1:0] dreq,
  input  logic                    dreqSenseLow,
  input  logic                    dackSenseHigh,
  input  logic                    rotatingPriority,
  input  logic                    controllerDisable,
  input  logic [NUM_CHANNELS-1:0] maskReg,
  input  logic [NUM_CHANNELS-1:0] swReqSet,
  input  logic                    assertDACK,
  input  logic                    deassertDACK,
  input  logic                    intEOP,
  output logic                    hrq,
  output logic [NUM_CHANNELS-1:0] dack,
  output logic [CH_W-1:0]         activeChannel,
  output logic                    channelValid,
  output logic [NUM_CHANNELS-1:0] swReq
);

  localparam int unsigned N = NUM_CHANNELS;

  resolverState_t  state_q;
  logic [N-1:0]    req_q;
  logic [N-1:0]    sw_req_q;
  logic [N-1:0]    sw_req_d;
  logic [N-1:0]    dack_q;
  logic [CH_W-1:0] active_q;
  logic [CH_W-1:0] ptr_q;
  logic            valid_q;
  logic            hrq_q;

  logic [N-1:0]    eff_req;
  logic [CH_W-1:0] arb_ptr;
  logic [CH_W-1:0] arb_winner;
  logic            arb_valid;

  assign eff_req = req_q & ~maskReg;
  assign arb_ptr = rotatingPriority ? ptr_q : '0;

  dma_rotating_arbiter #(
    .N    (N),
    .CH_W (CH_W)
  ) u_arbiter (
    .req_i    (eff_req),
    .ptr_i    (arb_ptr),
    .winner_o (arb_winner),
    .valid_o  (arb_valid)
  );

  // Software requests: intEOP clears the active bit, a same-cycle set wins.
  always_comb begin
    sw_req_d = sw_req_q;
    if (intEOP && valid_q) sw_req_d[active_q] = 1'b0;
    sw_req_d = sw_req_d | swReqSet;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      req_q    <= '0;
      sw_req_q <= '0;
      dack_q   <= '0;
      active_q <= '0;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      hrq_q    <= 1'b0;
    end else begin
      req_q    <= (dreq ^ {N{dreqSenseLow}}) | sw_req_q;
      sw_req_q <= sw_req_d;
      case (state_q)
        IDLE: begin
          if (arb_valid && !controllerDisable) begin
            state_q  <= REQ;
            active_q <= arb_winner;
            valid_q  <= 1'b1;
            hrq_q    <= 1'b1;
          end
        end
        REQ: begin
          // assertDACK takes precedence over a withdrawn request.
          if (assertDACK) begin
            state_q <= ACTIVE;
            dack_q  <= N'(1) << active_q;
          end else if (!eff_req[active_q]) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            hrq_q   <= 1'b0;
          end
        end
        ACTIVE: begin
          if (deassertDACK) begin
            state_q <= IDLE;
            dack_q  <= '0;
            valid_q <= 1'b0;
            hrq_q   <= 1'b0;
            ptr_q   <= CH_W'(nextPointer(32'(active_q), N));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hrq           = hrq_q;
  assign dack          = dack_q ^ {N{~dackSenseHigh}};
  assign activeChannel = active_q;
  assign channelValid  = valid_q;
  assign swReq         = sw_req_q;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed bench for dma_priority_resolver (N=4) with hand-computed expectations.
module tb_dma_priority_resolver;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] dreq;
  logic       dreqSenseLow;
  logic       dackSenseHigh;
  logic       rotatingPriority;
  logic       controllerDisable;
  logic [3:0] maskReg;
  logic [3:0] swReqSet;
  logic       assertDACK;
  logic       deassertDACK;
  logic       intEOP;
  logic       hrq;
  logic [3:0] dack;
  logic [1:0] activeChannel;
  logic       channelValid;
  logic [3:0] swReq;

  int checks = 0;
  int errors = 0;

  dma_priority_resolver #(.NUM_CHANNELS(4)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .dreq              (dreq),
    .dreqSenseLow      (dreqSenseLow),
    .dackSenseHigh     (dackSenseHigh),
    .rotatingPriority  (rotatingPriority),
    .controllerDisable (controllerDisable),
    .maskReg           (maskReg),
    .swReqSet          (swReqSet),
    .assertDACK        (assertDACK),
    .deassertDACK      (deassertDACK),
    .intEOP            (intEOP),
    .hrq               (hrq),
    .dack              (dack),
    .activeChannel     (activeChannel),
    .channelValid      (channelValid),
    .swReq             (swReq)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    RESET = 1'b1; dreq = '0; dreqSenseLow = 1'b0; dackSenseHigh = 1'b1;
    rotatingPriority = 1'b0; controllerDisable = 1'b0; maskReg = '0; swReqSet = '0;
    assertDACK = 1'b0; deassertDACK = 1'b0; intEOP = 1'b0;
    tick(2);
    chk("rst_hrq", 32'(hrq), 0);
    chk("rst_dack", 32'(dack), 'h0);
    chk("rst_active", 32'(activeChannel), 0);
    chk("rst_valid", 32'(channelValid), 0);
    chk("rst_swreq", 32'(swReq), 'h0);
    RESET = 1'b0;

    // Fixed priority, dreq=1010 held: channel 1 wins, hrq at cycle 2, dack cycles 5..8
    dreq = 4'b1010;
    tick(1);
    chk("fix_hrq_c1", 32'(hrq), 0);
    tick(1);
    chk("fix_hrq_c2", 32'(hrq), 1);
    chk("fix_active", 32'(activeChannel), 1);
    chk("fix_valid", 32'(channelValid), 1);
    chk("fix_dack_req", 32'(dack), 'h0);
    tick(2);
    assertDACK = 1'b1;
    tick(1);
    assertDACK = 1'b0;
    chk("fix_dack_c5", 32'(dack), 'h2);
    tick(3);
    chk("fix_dack_c8", 32'(dack), 'h2);
    deassertDACK = 1'b1;
    tick(1);
    deassertDACK = 1'b0;
    chk("fix_dack_off", 32'(dack), 'h0);
    chk("fix_hrq_off", 32'(hrq), 0);
    chk("fix_valid_off", 32'(channelValid), 0);
    tick(1);
    chk("fix_regrant", 32'(activeChannel), 1);
    chk("fix_regrant_hrq", 32'(hrq), 1);
    dreq = '0; assertDACK = 1'b1;
    tick(1);
    assertDACK = 1'b0; deassertDACK = 1'b1;
    tick(1);
    deassertDACK = 1'b0;
    tick(2);
    chk("fix_idle", 32'(hrq), 0);

    // Rotating, all requesting: order 0,1,2,3,0
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0; rotatingPriority = 1'b1; dreq = 4'b1111;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      chk("rot_hrq", 32'(hrq), 1);
      chk("rot_grant", 32'(activeChannel), 32'(exp_order[i]));
      assertDACK = 1'b1;
      tick(1);
      assertDACK = 1'b0;
      chk("rot_dack", 32'(dack), 32'(1) << exp_order[i]);
      deassertDACK = 1'b1;
      tick(1);
      deassertDACK = 1'b0;
      chk("rot_gap_hrq", 32'(hrq), 0);
      tick(1);
    end
    // Pending grant on channel 1 is withdrawn; pointer stays at 1
    dreq = '0;
    tick(2);
    chk("rot_withdraw", 32'(hrq), 0);

    // Request withdrawal: dreq[3] for two cycles, no assertDACK
    dreq = 4'b1000;
    tick(2);
    chk("wd_hrq", 32'(hrq), 1);
    chk("wd_active", 32'(activeChannel), 3);
    dreq = '0;
    tick(1);
    chk("wd_hold", 32'(hrq), 1);
    tick(1);
    chk("wd_drop_hrq", 32'(hrq), 0);
    chk("wd_drop_valid", 32'(channelValid), 0);
    dreq = 4'b1111;
    tick(2);
    chk("wd_ptr_kept", 32'(activeChannel), 1);
    dreq = '0; assertDACK = 1'b1;
    tick(1);
    assertDACK = 1'b0; deassertDACK = 1'b1;
    tick(1);
    deassertDACK = 1'b0;

    // Mask and software request
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0; rotatingPriority = 1'b0;
    maskReg = 4'b0001; dreq = 4'b0001; swReqSet = 4'b0100;
    tick(1);
    swReqSet = '0;
    chk("sw_set", 32'(swReq), 'h4);
    tick(1);
    chk("mask_block", 32'(hrq), 0);
    tick(1);
    chk("sw_hrq", 32'(hrq), 1);
    chk("sw_active", 32'(activeChannel), 2);
    assertDACK = 1'b1;
    tick(1);
    assertDACK = 1'b0;
    chk("sw_dack", 32'(dack), 'h4);
    intEOP = 1'b1;
    tick(1);
    intEOP = 1'b0;
    chk("eop_clear", 32'(swReq), 'h0);
    chk("eop_no_exit", 32'(hrq), 1);
    deassertDACK = 1'b1;
    tick(1);
    deassertDACK = 1'b0;
    tick(3);
    chk("mask_never", 32'(hrq), 0);
    // Same-cycle set and intEOP: set wins
    swReqSet = 4'b0100;
    tick(1);
    swReqSet = '0;
    tick(2);
    chk("sw2_active", 32'(activeChannel), 2);
    assertDACK = 1'b1;
    tick(1);
    assertDACK = 1'b0; intEOP = 1'b1; swReqSet = 4'b0100;
    tick(1);
    swReqSet = '0;
    chk("eop_set_wins", 32'(swReq), 'h4);
    tick(1);
    intEOP = 1'b0;
    chk("eop_clear2", 32'(swReq), 'h0);
    deassertDACK = 1'b1;
    tick(1);
    deassertDACK = 1'b0; maskReg = '0; dreq = '0;
    tick(3);
    chk("sw2_idle", 32'(hrq), 0);

    // controllerDisable blocks new grants; dual strobe in REQ acts as assertDACK
    controllerDisable = 1'b1; dreq = 4'b0010;
    tick(3);
    chk("dis_block", 32'(hrq), 0);
    controllerDisable = 1'b0;
    tick(1);
    chk("dis_release", 32'(hrq), 1);
    chk("dis_active", 32'(activeChannel), 1);
    assertDACK = 1'b1; deassertDACK = 1'b1; dreq = '0;
    tick(1);
    assertDACK = 1'b0; deassertDACK = 1'b0;
    chk("dual_dack", 32'(dack), 'h2);
    chk("dual_hrq", 32'(hrq), 1);
    deassertDACK = 1'b1;
    tick(1);
    deassertDACK = 1'b0;
    chk("dual_done", 32'(hrq), 0);

    // Polarity: active-low dreq and dack
    dackSenseHigh = 1'b0; dreqSenseLow = 1'b1; dreq = 4'b1110;
    #1;
    chk("pol_idle_dack", 32'(dack), 'hF);
    tick(2);
    chk("pol_active", 32'(activeChannel), 0);
    chk("pol_req_dack", 32'(dack), 'hF);
    assertDACK = 1'b1;
    tick(1);
    assertDACK = 1'b0;
    chk("pol_dack", 32'(dack), 'hE);
    dreq = 4'b1111; deassertDACK = 1'b1;
    tick(1);
    deassertDACK = 1'b0;
    chk("pol_dack_off", 32'(dack), 'hF);
    tick(2);
    chk("pol_idle_hrq", 32'(hrq), 0);

    // RESET mid-ACTIVE on channel 2 in rotating mode
    dreqSenseLow = 1'b0; dackSenseHigh = 1'b1; dreq = 4'b0100; rotatingPriority = 1'b1;
    tick(2);
    chk("rr_active", 32'(activeChannel), 2);
    assertDACK = 1'b1;
    tick(1);
    assertDACK = 1'b0; swReqSet = 4'b1000;
    chk("rr_dack", 32'(dack), 'h4);
    tick(1);
    swReqSet = '0;
    chk("rr_swreq", 32'(swReq), 'h8);
    RESET = 1'b1; dreq = 4'b1111;
    tick(1);
    RESET = 1'b0;
    chk("rr_hrq", 32'(hrq), 0);
    chk("rr_dack_off", 32'(dack), 'h0);
    chk("rr_swreq_off", 32'(swReq), 'h0);
    chk("rr_valid", 32'(channelValid), 0);
    chk("rr_active0", 32'(activeChannel), 0);
    tick(2);
    chk("rr_ptr0_hrq", 32'(hrq), 1);
    chk("rr_ptr0_grant", 32'(activeChannel), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
